multicycle_control_fsm: RTL

//  Multi-cycle MIPS control sequencer. Drives datapath muxes and enables state-by-state for R-type, lw, sw, beq, ori and j.

---
 rtl/mips_ctrl_pkg.sv | 70 +++++++
 rtl/ctrl_output_decode.sv | 85 ++++++++
 rtl/multicycle_control_fsm.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_pkg
// Brief    : Shared constants for the multi-cycle MIPS control path: opcodes,
//            ALU operation codes, datapath select codes, state encodings and
//            the packed control vector driven into the datapath.
// Revision : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALUOp codes consumed by the ALU control block
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    // ALU B-operand select
    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Sequencer state encodings (codes 13..15 are unused)
    localparam int unsigned STATE_CODE_W = 4;
    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_MEMADR = 4'd2;
    localparam logic [3:0] ST_MEMRD  = 4'd3;
    localparam logic [3:0] ST_MEMWB  = 4'd4;
    localparam logic [3:0] ST_MEMWR  = 4'd5;
    localparam logic [3:0] ST_EXEC   = 4'd6;
    localparam logic [3:0] ST_RWB    = 4'd7;
    localparam logic [3:0] ST_BEQ    = 4'd8;
    localparam logic [3:0] ST_ORIEX  = 4'd9;
    localparam logic [3:0] ST_ORIWB  = 4'd10;
    localparam logic [3:0] ST_JUMP   = 4'd11;
    localparam logic [3:0] ST_HALT   = 4'd12;

    // Full set of datapath controls produced each cycle
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_vec_t;

endpackage : mips_ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_output_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_output_decode
// Brief    : Combinational map from sequencer state (plus mem_ready for the
//            Mealy fetch enables) to the datapath control vector.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_output_decode
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned STATE_W = 4   // must be >= STATE_CODE_W
) (
    input  logic [STATE_W-1:0] i_state,
    input  logic               i_mem_ready,
    output ctrl_vec_t          o_ctrl
);

    // Per-state control decode; anything not set stays 0 (HALT and unused codes)
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            STATE_W'(ST_FETCH): begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.pc_source = PCSRC_ALU;
                // IR and PC only update on the cycle memory delivers the word
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            STATE_W'(ST_DECODE): begin
                o_ctrl.alu_src_b = SRCB_IMM_SH2;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            STATE_W'(ST_MEMADR): begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            STATE_W'(ST_MEMRD): begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            STATE_W'(ST_MEMWB): begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            STATE_W'(ST_MEMWR): begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
            end
            STATE_W'(ST_EXEC): begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_RT;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            STATE_W'(ST_RWB): begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            STATE_W'(ST_BEQ): begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRCB_RT;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
            end
            STATE_W'(ST_ORIEX): begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_OR;
            end
            STATE_W'(ST_ORIWB): begin
                o_ctrl.reg_write = 1'b1;
            end
            STATE_W'(ST_JUMP): begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule : ctrl_output_decode
`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_fsm
// Brief    : Multi-cycle MIPS control sequencer (R-type, lw, sw, beq, ori, j)
//            with a single memory-ready stall and a sticky illegal flag.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned STATE_W = 4,     // must be >= STATE_CODE_W
    parameter bit          JUMP_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               illegal,
    output logic [STATE_W-1:0] dbg_state
);

    localparam logic [STATE_W-1:0] c_fetch  = STATE_W'(ST_FETCH);
    localparam logic [STATE_W-1:0] c_decode = STATE_W'(ST_DECODE);
    localparam logic [STATE_W-1:0] c_memadr = STATE_W'(ST_MEMADR);
    localparam logic [STATE_W-1:0] c_memrd  = STATE_W'(ST_MEMRD);
    localparam logic [STATE_W-1:0] c_memwb  = STATE_W'(ST_MEMWB);
    localparam logic [STATE_W-1:0] c_memwr  = STATE_W'(ST_MEMWR);
    localparam logic [STATE_W-1:0] c_exec   = STATE_W'(ST_EXEC);
    localparam logic [STATE_W-1:0] c_rwb    = STATE_W'(ST_RWB);
    localparam logic [STATE_W-1:0] c_beq    = STATE_W'(ST_BEQ);
    localparam logic [STATE_W-1:0] c_oriex  = STATE_W'(ST_ORIEX);
    localparam logic [STATE_W-1:0] c_oriwb  = STATE_W'(ST_ORIWB);
    localparam logic [STATE_W-1:0] c_jump   = STATE_W'(ST_JUMP);
    localparam logic [STATE_W-1:0] c_halt   = STATE_W'(ST_HALT);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    logic [5:0]         r_opcode;
    logic               r_illegal;
    logic               w_set_illegal;
    ctrl_vec_t          w_ctrl;

    // State register, DECODE-time opcode capture and sticky illegal flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_fetch;
            r_opcode  <= OP_RTYPE;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == c_decode) begin
                r_opcode <= opcode;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Next-state sequencing; the opcode port is only looked at in DECODE
    always_comb begin
        w_next_state  = c_fetch;
        w_set_illegal = 1'b0;
        case (r_state)
            c_fetch:  w_next_state = mem_ready ? c_decode : c_fetch;
            c_decode: begin
                case (opcode)
                    OP_RTYPE:     w_next_state = c_exec;
                    OP_LW, OP_SW: w_next_state = c_memadr;
                    OP_BEQ:       w_next_state = c_beq;
                    OP_ORI:       w_next_state = c_oriex;
                    OP_J: begin
                        if (JUMP_EN) begin
                            w_next_state = c_jump;
                        end else begin
                            w_next_state  = c_halt;
                            w_set_illegal = 1'b1;
                        end
                    end
                    default: begin
                        w_next_state  = c_halt;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            // Only lw/sw reach MEMADR, so anything other than lw is a store
            c_memadr: w_next_state = (r_opcode == OP_LW) ? c_memrd : c_memwr;
            c_memrd:  w_next_state = mem_ready ? c_memwb : c_memrd;
            c_memwb:  w_next_state = c_fetch;
            c_memwr:  w_next_state = mem_ready ? c_fetch : c_memwr;
            c_exec:   w_next_state = c_rwb;
            c_rwb:    w_next_state = c_fetch;
            c_beq:    w_next_state = c_fetch;
            c_oriex:  w_next_state = c_oriwb;
            c_oriwb:  w_next_state = c_fetch;
            c_jump:   w_next_state = c_fetch;
            c_halt:   w_next_state = c_halt;
            default:  w_next_state = c_fetch;   // unused codes recover
        endcase
    end

    ctrl_output_decode #(
        .STATE_W (STATE_W)
    ) u_ctrl_output_decode (
        .i_state     (r_state),
        .i_mem_ready (mem_ready),
        .o_ctrl      (w_ctrl)
    );

    assign PCWrite     = w_ctrl.pc_write;
    assign PCWriteCond = w_ctrl.pc_write_cond;
    assign IorD        = w_ctrl.iord;
    assign MemRead     = w_ctrl.mem_read;
    assign MemWrite    = w_ctrl.mem_write;
    assign IRWrite     = w_ctrl.ir_write;
    assign MemtoReg    = w_ctrl.mem_to_reg;
    assign RegDst      = w_ctrl.reg_dst;
    assign RegWrite    = w_ctrl.reg_write;
    assign ALUSrcA     = w_ctrl.alu_src_a;
    assign ALUSrcB     = w_ctrl.alu_src_b;
    assign ALUOp       = w_ctrl.alu_op;
    assign PCSource    = w_ctrl.pc_source;
    assign illegal     = r_illegal;
    assign dbg_state   = r_state;

endmodule : multicycle_control_fsm
`default_nettype wire
